temp_display_scheduler: RTL and testbench
=========================================

TEMP_DISPLAY_SCHEDULER -- requirements
Module: temp_display_scheduler

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (legal 2..2^20).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of scanned anodes (legal 3..8).
REQ-003 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-004 Port: clock  input  1  single rising-edge clock for all state.
REQ-005 Port: reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-006 Port: temp_in  input  8  unsigned binary temperature, 0..255, sampled only on an accepted request.
REQ-007 Port: temp_valid  input  1  request to convert and display temp_in.
REQ-008 Port: temp_ready  output  1  high when a request is accepted this cycle.
REQ-009 Port: blank  input  1  forces all segments off while high; the scan continues.
REQ-010 Port: update_done  output  1  one-cycle pulse when new digits are committed to the display.
REQ-011 Port: dropped  output  1  one-cycle pulse when temp_valid is high while temp_ready is low.
REQ-012 Port: out_anode  output  8  active-low digit enables; bit k = digit k; bits >= NUM_DIGITS are held 1.
REQ-013 Port: out_cathode  output  7  active-low segments, bit6 = A ... bit0 = G.

Function
REQ-014 Conversion FSM SHALL have states IDLE, SHIFT and COMMIT; temp_ready SHALL equal (state == IDLE).
REQ-015 IDLE with temp_valid=1: capture temp_in, clear the BCD shift register (12 bits), set the bit counter to 0, and go to SHIFT.
REQ-016 SHIFT SHALL perform one double-dabble step per cycle: add 3 to each BCD nibble >= 5, then shift left with the next input bit, MSB first.
REQ-017 SHIFT SHALL last exactly 8 cycles, then go to COMMIT.
REQ-018 COMMIT SHALL, in one cycle, load the hundreds, tens and ones display registers together, pulse update_done, and return to IDLE.
REQ-019 Latency: request accepted at edge N; update_done high in cycle N+9; temp_ready high again in cycle N+10.
REQ-020 Display registers SHALL change only in COMMIT; the displayed value never shows partial conversion results.
REQ-021 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-022 On wrap, the digit index SHALL advance and SHALL go from NUM_DIGITS-1 to 0.
REQ-023 Exactly one out_anode bit SHALL be 0 at any time outside reset, the bit equal to the digit index.
REQ-024 Digit map: digit 0 = ones, digit 1 = tens, digit 2 = hundreds, digits 3+ = blank (cathode 7'h7F).
REQ-025 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds=0 and tens=0; ones is never blanked.
REQ-026 Segment code, active-low ABCDEFG:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
REQ-027 blank=1 SHALL force out_cathode to 7'h7F from the next edge; the anode scan continues unchanged.
REQ-028 out_anode and out_cathode SHALL be registered; they are updated on the same edge as the digit index, so they always describe the same digit.
REQ-029 temp_valid while not in IDLE SHALL be ignored, and dropped SHALL pulse for each such cycle.
REQ-030 Conversion SHALL be independent of the scan: a COMMIT mid-slot changes the cathode from the next edge onward.

Reset
REQ-031 While reset=0, all outputs SHALL be held at these values, and the values SHALL apply asynchronously on assertion:
  - out_anode = 8'hFF, out_cathode = 7'h7F
  - temp_ready = 0, update_done = 0, dropped = 0
REQ-032 While reset=0, internal state SHALL be: FSM = IDLE, refresh counter = 0, digit index = 0, display registers = 0,0,0.
REQ-033 On the first edge after reset release, the block SHALL drive out_anode = 8'hFE and out_cathode = 7'b0000001 ("0"), and set temp_ready = 1.
REQ-034 Reset asserted during SHIFT or COMMIT SHALL abort the conversion with no update_done pulse; the display returns to "0".

Verification
REQ-035 Reset release, REFRESH_DIV=4, no request -> anode sequence FE,FD,FB,...,7F,FE every 4 cycles; cathode 0000001 on digit 0 and 1111111 on all other digits.
REQ-036 temp_in=25 accepted at edge N -> update_done at N+9; digit0 = 0100100, digit1 = 0010010, digit2 blank.
REQ-037 temp_in=255 -> digits 5,5,2; temp_in=100 -> 0,0,1 (tens not blanked); temp_in=7 -> 7 with two blanks.
REQ-038 temp_valid held high for 12 cycles -> one conversion; dropped pulses for 9 cycles; second acceptance at N+10.
REQ-039 reset pulled low at N+4 of a conversion of 99 -> outputs FF/7F immediately; no update_done; after release, digit 0 shows "0".
REQ-040 blank=1 for 3 slots during display of 23 -> cathode 7F, anodes still rotate; blank=0 -> "23" restored on the next edge.

Source files
------------

// File: rtl/temp_display_scheduler.sv
// Temperature display: converts an 8-bit binary reading to BCD with a serial
// double-dabble FSM and time-multiplexes the digits onto a 7-segment display.
module temp_display_scheduler #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] temp_in,
    input  logic       temp_valid,
    output logic       temp_ready,
    input  logic       blank,
    output logic       update_done,
    output logic       dropped,
    output logic [7:0] out_anode,
    output logic [6:0] out_cathode
);

    localparam int              CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   RMAX = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]      DMAX = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]      SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t        state;
    logic          ready_q;
    logic          done_q;
    logic [7:0]    bin;
    logic [11:0]   bcd;
    logic [2:0]    bit_cnt;
    logic [3:0]    hund_q, tens_q, ones_q;

    logic [CW-1:0] refresh_cnt;
    logic [2:0]    digit_idx;
    logic [7:0]    anode_q;
    logic [6:0]    cathode_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_OFF;
        endcase
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] n);
        dabble = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // An 8-bit input keeps the hundreds nibble at or below 2 before each
    // step, so only tens and ones ever need the +3 correction.
    logic [10:0] dd_adj;
    assign dd_adj = {bcd[10:8], dabble(bcd[7:4]), dabble(bcd[3:0])};

    assign temp_ready  = ready_q;
    assign update_done = done_q;
    assign dropped     = temp_valid && (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (temp_valid && ready_q) begin
                        bin     <= temp_in;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        ready_q <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd     <= {dd_adj, bin[7]};
                    bin     <= {bin[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        done_q <= 1'b1;
                        state  <= COMMIT;
                    end
                end
                COMMIT: begin
                    hund_q  <= bcd[11:8];
                    tens_q  <= bcd[7:4];
                    ones_q  <= bcd[3:0];
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic       slot_wrap;
    logic [2:0] idx_next;
    assign slot_wrap = (refresh_cnt == RMAX);
    assign idx_next  = !slot_wrap ? digit_idx :
                       (digit_idx == DMAX) ? 3'd0 : digit_idx + 3'd1;

    // The segment register loads from the values being committed this cycle,
    // so the new reading appears on the commit edge itself.
    logic [3:0] hund_n, tens_n, ones_n;
    logic [6:0] cathode_n;
    logic [7:0] anode_n;

    always_comb begin
        hund_n = hund_q;
        tens_n = tens_q;
        ones_n = ones_q;
        if (state == COMMIT) begin
            hund_n = bcd[11:8];
            tens_n = bcd[7:4];
            ones_n = bcd[3:0];
        end
    end

    always_comb begin
        cathode_n = SEG_OFF;
        case (idx_next)
            3'd0: cathode_n = seg7(ones_n);
            3'd1: cathode_n = (hund_n == 4'd0 && tens_n == 4'd0) ? SEG_OFF : seg7(tens_n);
            3'd2: cathode_n = (hund_n == 4'd0) ? SEG_OFF : seg7(hund_n);
            default: cathode_n = SEG_OFF;
        endcase
        if (blank)
            cathode_n = SEG_OFF;
    end

    always_comb begin
        anode_n           = 8'hFF;
        anode_n[idx_next] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            anode_q     <= 8'hFF;
            cathode_q   <= SEG_OFF;
        end else begin
            refresh_cnt <= slot_wrap ? '0 : refresh_cnt + 1'b1;
            digit_idx   <= idx_next;
            anode_q     <= anode_n;
            cathode_q   <= cathode_n;
        end
    end

    assign out_anode   = anode_q;
    assign out_cathode = cathode_q;

endmodule

// File: tb/tb_temp_display_scheduler.sv
// Scoreboard bench for temp_display_scheduler: a decimal reference model
// predicts handshake, commit timing and every scanned digit.
module tb_temp_display_scheduler;

    localparam int DIV = 4;
    localparam int ND  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] temp_in = 8'd0;
    logic       temp_valid = 1'b0;
    logic       temp_ready;
    logic       blank = 1'b0;
    logic       update_done;
    logic       dropped;
    logic [7:0] out_anode;
    logic [6:0] out_cathode;

    temp_display_scheduler #(.REFRESH_DIV(DIV), .NUM_DIGITS(ND)) dut (
        .clock(clock), .reset(reset), .temp_in(temp_in), .temp_valid(temp_valid),
        .temp_ready(temp_ready), .blank(blank), .update_done(update_done),
        .dropped(dropped), .out_anode(out_anode), .out_cathode(out_cathode)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                        7'b0000000, 7'b0000100};

    function automatic logic [6:0] exp_cath(input int d, input int v);
        if (d == 0) return SEG[v % 10];
        if (d == 1) return (v < 10) ? 7'h7F : SEG[(v / 10) % 10];
        if (d == 2) return (v < 100) ? 7'h7F : SEG[v / 100];
        return 7'h7F;
    endfunction

    // edges seen since reset release
    int cyc;
    always @(posedge clock or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    typedef struct {int val; int done;} exp_t;
    exp_t q[$];
    exp_t e;
    int   shown = 0, next_shown = 0, next_at = 1 << 30, last_acc = -100, d;
    bit   blank_prev = 1'b0, rdy_exp;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_anode", 32'(out_anode), 32'hFF);
            check("rst_cathode", 32'(out_cathode), 32'h7F);
            check("rst_ready", 32'(temp_ready), 0);
            check("rst_done", 32'(update_done), 0);
            check("rst_dropped", 32'(dropped), 0);
            q.delete();
            shown = 0; next_at = 1 << 30; last_acc = -100; blank_prev = 1'b0;
        end else if (cyc == 0) begin
            check("pre_anode", 32'(out_anode), 32'hFF);
            check("pre_cathode", 32'(out_cathode), 32'h7F);
            check("pre_ready", 32'(temp_ready), 0);
            blank_prev = blank;
        end else begin
            if (cyc >= next_at) begin
                shown   = next_shown;
                next_at = 1 << 30;
            end
            rdy_exp = !(cyc >= last_acc && cyc <= last_acc + 8);
            check("ready", 32'(temp_ready), 32'(rdy_exp));
            check("dropped", 32'(dropped), 32'(temp_valid && !rdy_exp));
            d = (cyc / DIV) % ND;
            check("anode", 32'(out_anode), 32'(8'hFF & ~(8'h01 << d)));
            check("cathode", 32'(out_cathode), 32'(blank_prev ? 7'h7F : exp_cath(d, shown)));
            if (update_done) begin
                if (q.size() == 0) begin
                    check("done_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done));
                    next_shown = e.val;
                    next_at    = cyc + 1;
                end
            end else if (q.size() > 0 && q[0].done < cyc) begin
                check("done_missing", 0, 1);
                e = q.pop_front();
                shown = e.val;
            end
            if (temp_valid && rdy_exp) begin
                last_acc = cyc + 1;
                e.val  = int'(temp_in);
                e.done = cyc + 9;
                q.push_back(e);
            end
            blank_prev = blank;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input int v);
        int k = 0;
        temp_in    = 8'(v);
        temp_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (temp_ready) break;
            k++;
            if (k > 30) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock);
        #1;
        temp_valid = 1'b0;
    endtask

    int vals [6] = '{25, 255, 100, 7, 0, 23};

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        idle(40);
        foreach (vals[i]) begin
            send(vals[i]);
            idle(40);
        end
        // blank over three slots while "23" is shown
        blank = 1'b1;
        idle(12);
        blank = 1'b0;
        idle(10);
        // request held through a whole conversion
        temp_in    = 8'($urandom_range(0, 255));
        temp_valid = 1'b1;
        idle(12);
        temp_valid = 1'b0;
        idle(40);
        repeat (400) begin
            temp_valid = ($urandom_range(0, 2) == 0);
            temp_in    = 8'($urandom_range(0, 255));
            blank      = ($urandom_range(0, 15) == 0);
            idle(1);
        end
        temp_valid = 1'b0;
        blank      = 1'b0;
        idle(40);
        // reset in the middle of converting 99
        send(99);
        idle(3);
        reset = 1'b0;
        #1;
        check("async_anode", 32'(out_anode), 32'hFF);
        check("async_cathode", 32'(out_cathode), 32'h7F);
        check("async_ready", 32'(temp_ready), 0);
        check("async_done", 32'(update_done), 0);
        idle(3);
        reset = 1'b1;
        idle(30);
        check("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
